dds_sweep_controller: RTL and testbench

DDS_SWEEP_CONTROLLER -- requirements
Module: dds_sweep_controller

---
 rtl/dds_sweep_pkg.sv | 30 +++
 rtl/dds_sweep_dwell_timer.sv | 32 +++
 rtl/dds_sweep_controller.sv | 194 +++++++++++++++++++
 tb/tb_dds_sweep_controller.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dds_sweep_pkg.sv
// Shared definitions for the DDS frequency-sweep controller:
// the state encoding, the sweep mode codes and the default widths.
package dds_sweep_pkg;

    localparam int unsigned DEFAULT_PHASE_WORD_WIDTH = 32;
    localparam int unsigned DEFAULT_DWELL_WIDTH      = 24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        DWELL = 2'd2,
        DONE  = 2'd3
    } sweep_state_t;

    typedef enum logic [1:0] {
        SINGLE = 2'd0,
        REPEAT = 2'd1,
        UPDOWN = 2'd2
    } sweep_mode_t;

    // The reserved code 3 behaves as a single sweep.
    function automatic sweep_mode_t decode_mode(input logic [1:0] code);
        case (code)
            2'd1:    return REPEAT;
            2'd2:    return UPDOWN;
            default: return SINGLE;
        endcase
    endfunction

endpackage

// File: rtl/dds_sweep_dwell_timer.sv
// Loadable down-counter that measures how long each sweep frequency is held.
// o_tc is high while the count is zero, i.e. during the last dwell cycle.
module dds_sweep_dwell_timer
    import dds_sweep_pkg::*;
#(
    parameter int unsigned _DWELL_WIDTH = DEFAULT_DWELL_WIDTH
) (
    input  logic                    i_clk,
    input  logic                    i_reset_n,
    input  logic                    i_load,
    input  logic [_DWELL_WIDTH-1:0] i_load_value,
    input  logic                    i_dec,
    output logic [_DWELL_WIDTH-1:0] o_count,
    output logic                    o_tc
);

    logic [_DWELL_WIDTH-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_tc    = (r_count == '0);

endmodule

// File: rtl/dds_sweep_controller.sv
// Drives a DDS core phase-step input through a linear frequency sweep
// (single, repeating or up-down) with a programmable dwell per frequency.
module dds_sweep_controller
    import dds_sweep_pkg::*;
#(
    parameter int unsigned _PHASE_WORD_WIDTH = DEFAULT_PHASE_WORD_WIDTH,
    parameter int unsigned _DWELL_WIDTH      = DEFAULT_DWELL_WIDTH
) (
    input  logic                         i_clk,
    input  logic                         i_reset_n,
    input  logic                         i_start,
    input  logic                         i_stop,
    input  logic [_PHASE_WORD_WIDTH-1:0] i_StartPhaseStep,
    input  logic [_PHASE_WORD_WIDTH-1:0] i_StopPhaseStep,
    input  logic [_PHASE_WORD_WIDTH-1:0] i_StepIncrement,
    input  logic [_DWELL_WIDTH-1:0]      i_DwellCycles,
    input  logic [1:0]                   i_Mode,
    output logic [_PHASE_WORD_WIDTH-1:0] o_PhaseStep,
    output logic                         o_phase_reset,
    output logic                         o_busy,
    output logic                         o_done,
    output logic                         o_marker
);

    localparam int unsigned PW = _PHASE_WORD_WIDTH;
    localparam int unsigned DW = _DWELL_WIDTH;
    localparam logic [DW-1:0] DWELL_ONE = DW'(1);

    sweep_state_t  r_state;
    sweep_mode_t   r_mode;
    logic [PW-1:0] r_start;
    logic [PW-1:0] r_stop;
    logic [PW-1:0] r_inc;
    logic [PW-1:0] r_target;
    logic [PW-1:0] r_phase;
    logic [DW-1:0] r_dwell_m1;
    logic          r_up;
    logic          r_toward_stop;
    logic          r_phase_reset;
    logic          r_busy;
    logic          r_done;
    logic          r_marker;

    logic [PW-1:0] w_step;
    logic [PW-1:0] w_rev_tgt;
    logic [PW-1:0] w_rev_step;
    logic [DW-1:0] w_dwell_m1_in;
    logic [DW-1:0] w_count;
    logic          w_tc;
    logic          w_at_end;
    logic          w_last_dwell;
    logic          w_load;
    logic          w_dec;

    // One step toward tgt, computed one bit wider so carry/borrow clamp to tgt.
    function automatic logic [PW-1:0] step_toward(
        input logic [PW-1:0] cur,
        input logic [PW-1:0] inc,
        input logic [PW-1:0] tgt,
        input logic          up
    );
        logic [PW:0] ext;
        if (up) begin
            ext = {1'b0, cur} + {1'b0, inc};
            if (ext > {1'b0, tgt}) return tgt;
        end else begin
            ext = {1'b0, cur} - {1'b0, inc};
            if (ext[PW] || (ext[PW-1:0] < tgt)) return tgt;
        end
        return ext[PW-1:0];
    endfunction

    always_comb begin
        w_step        = step_toward(r_phase, r_inc, r_target, r_up);
        w_rev_tgt     = r_toward_stop ? r_start : r_stop;
        w_rev_step    = step_toward(r_phase, r_inc, w_rev_tgt, ~r_up);
        w_at_end      = (r_phase == r_target);
        w_last_dwell  = (r_dwell_m1 == '0);
        w_dwell_m1_in = (i_DwellCycles == '0) ? '0 : i_DwellCycles - 1'b1;
        w_load        = (r_state == ARM) || ((r_state == DWELL) && w_tc);
        w_dec         = (r_state == DWELL);
    end

    dds_sweep_dwell_timer #(
        ._DWELL_WIDTH(DW)
    ) u_dwell_timer (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_load      (w_load),
        .i_load_value(r_dwell_m1),
        .i_dec       (w_dec),
        .o_count     (w_count),
        .o_tc        (w_tc)
    );

    // o_marker is registered one cycle ahead so it is high during the last
    // dwell cycle of an endpoint word, i.e. while the endpoint decision is taken.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state       <= IDLE;
            r_mode        <= SINGLE;
            r_start       <= '0;
            r_stop        <= '0;
            r_inc         <= '0;
            r_target      <= '0;
            r_phase       <= '0;
            r_dwell_m1    <= '0;
            r_up          <= 1'b1;
            r_toward_stop <= 1'b1;
            r_phase_reset <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_marker      <= 1'b0;
        end else begin
            r_phase_reset <= 1'b0;
            r_done        <= 1'b0;
            r_marker      <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start && !i_stop) begin
                        r_state       <= ARM;
                        r_mode        <= decode_mode(i_Mode);
                        r_start       <= i_StartPhaseStep;
                        r_stop        <= i_StopPhaseStep;
                        r_inc         <= i_StepIncrement;
                        r_target      <= i_StopPhaseStep;
                        r_phase       <= i_StartPhaseStep;
                        r_dwell_m1    <= w_dwell_m1_in;
                        r_up          <= (i_StopPhaseStep >= i_StartPhaseStep);
                        r_toward_stop <= 1'b1;
                        r_phase_reset <= 1'b1;
                        r_busy        <= 1'b1;
                    end
                end
                ARM: begin
                    if (i_stop) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state  <= DWELL;
                        r_marker <= w_last_dwell && w_at_end;
                    end
                end
                DWELL: begin
                    if (i_stop) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (w_tc) begin
                        if (w_at_end) begin
                            case (r_mode)
                                REPEAT: begin
                                    r_phase  <= r_start;
                                    r_marker <= w_last_dwell && (r_start == r_target);
                                end
                                UPDOWN: begin
                                    r_phase       <= w_rev_step;
                                    r_target      <= w_rev_tgt;
                                    r_up          <= ~r_up;
                                    r_toward_stop <= ~r_toward_stop;
                                    r_marker      <= w_last_dwell && (w_rev_step == w_rev_tgt);
                                end
                                default: begin
                                    r_state <= DONE;
                                    r_busy  <= 1'b0;
                                    r_done  <= 1'b1;
                                end
                            endcase
                        end else begin
                            r_phase  <= w_step;
                            r_marker <= w_last_dwell && (w_step == r_target);
                        end
                    end else begin
                        r_marker <= (w_count == DWELL_ONE) && w_at_end;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_PhaseStep   = r_phase;
    assign o_phase_reset = r_phase_reset;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_marker      = r_marker;

endmodule

// File: tb/tb_dds_sweep_controller.sv
// Self-checking bench for dds_sweep_controller: directed vector table,
// randomized sweeps against a cycle-trace model, and reset/priority sequences.
module tb_dds_sweep_controller;

    logic        clk;
    logic        rst_n;
    logic        i_start;
    logic        i_stop;
    logic [31:0] i_StartPhaseStep;
    logic [31:0] i_StopPhaseStep;
    logic [31:0] i_StepIncrement;
    logic [23:0] i_DwellCycles;
    logic [1:0]  i_Mode;
    logic [31:0] o_PhaseStep;
    logic        o_phase_reset;
    logic        o_busy;
    logic        o_done;
    logic        o_marker;

    int n_err = 0;
    int n_chk = 0;

    // Expected per-cycle outputs packed as {phase[31:0], phase_reset, busy, done, marker}
    logic [35:0] q_exp[$];
    logic [31:0] q_words[$];
    int          g_done_at;

    typedef struct {
        logic [31:0]       s;
        logic [31:0]       e;
        logic [31:0]       inc;
        logic [23:0]       dw;
        logic [1:0]        md;
        int                stop_at;
        int                done_cyc;
        int                nw;
        logic [7:0][31:0]  w;
    } vec_t;

    vec_t vt[9];

    dds_sweep_controller #(
        ._PHASE_WORD_WIDTH(32),
        ._DWELL_WIDTH(24)
    ) dut (
        .i_clk           (clk),
        .i_reset_n       (rst_n),
        .i_start         (i_start),
        .i_stop          (i_stop),
        .i_StartPhaseStep(i_StartPhaseStep),
        .i_StopPhaseStep (i_StopPhaseStep),
        .i_StepIncrement (i_StepIncrement),
        .i_DwellCycles   (i_DwellCycles),
        .i_Mode          (i_Mode),
        .o_PhaseStep     (o_PhaseStep),
        .o_phase_reset   (o_phase_reset),
        .o_busy          (o_busy),
        .o_done          (o_done),
        .o_marker        (o_marker)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [35:0] pk(input longint ph, input bit pr, input bit b,
                                       input bit d, input bit m);
        logic [31:0] p;
        p = ph[31:0];
        return {p, pr, b, d, m};
    endfunction

    function automatic longint step(input longint cur, input longint inc,
                                    input longint tgt, input bit up);
        longint n;
        if (up) begin
            n = cur + inc;
            return (n > tgt) ? tgt : n;
        end
        n = cur - inc;
        return (n < tgt) ? tgt : n;
    endfunction

    // Behavioural sweep: list of words, each held D cycles, endpoint rules applied.
    task automatic build_model(input logic [31:0] s, input logic [31:0] e,
                               input logic [31:0] inc, input logic [23:0] dw,
                               input logic [1:0] md, input int stop_at);
        longint cur, tgt, oth, tmp, last;
        bit     up, fin;
        int     d;
        q_exp.delete();
        d   = (dw == 0) ? 1 : int'(dw);
        cur = longint'(s);
        tgt = longint'(e);
        oth = longint'(s);
        up  = (e >= s);
        fin = 0;
        q_exp.push_back(pk(cur, 1, 1, 0, 0));
        while (!fin && q_exp.size() < 150) begin
            for (int j = 0; j < d; j++)
                q_exp.push_back(pk(cur, 0, 1, 0, (j == d - 1) && (cur == tgt)));
            if (cur == tgt) begin
                if (md == 2'd1) begin
                    cur = longint'(s);
                end else if (md == 2'd2) begin
                    tmp = tgt; tgt = oth; oth = tmp;
                    up  = !up;
                    cur = step(cur, longint'(inc), tgt, up);
                end else begin
                    fin = 1;
                end
            end else begin
                cur = step(cur, longint'(inc), tgt, up);
            end
        end
        if (stop_at >= 0 && stop_at < q_exp.size())
            while (q_exp.size() > stop_at + 1) void'(q_exp.pop_back());
        last = longint'(q_exp[q_exp.size() - 1][35:4]);
        q_exp.push_back(pk(last, 0, 0, 1, 0));
        q_exp.push_back(pk(last, 0, 0, 0, 0));
        q_exp.push_back(pk(last, 0, 0, 0, 0));
    endtask

    task automatic rand_cfg();
        i_StartPhaseStep = $urandom;
        i_StopPhaseStep  = $urandom;
        i_StepIncrement  = $urandom;
        i_DwellCycles    = 24'($urandom);
        i_Mode           = 2'($urandom);
    endtask

    task automatic run_sweep(input logic [31:0] s, input logic [31:0] e,
                             input logic [31:0] inc, input logic [23:0] dw,
                             input logic [1:0] md, input int stop_at, input int tag);
        build_model(s, e, inc, dw, md, stop_at);
        q_words.delete();
        g_done_at = -1;
        @(negedge clk);
        i_StartPhaseStep = s;
        i_StopPhaseStep  = e;
        i_StepIncrement  = inc;
        i_DwellCycles    = dw;
        i_Mode           = md;
        i_start          = 1'b1;
        i_stop           = 1'b0;
        for (int c = 0; c < q_exp.size(); c++) begin
            @(negedge clk);
            chk($sformatf("sweep%0d cyc%0d {phase,prst,busy,done,mark}", tag, c),
                {28'd0, o_PhaseStep, o_phase_reset, o_busy, o_done, o_marker},
                {28'd0, q_exp[c]});
            if (o_busy && (q_words.size() == 0 || q_words[q_words.size() - 1] != o_PhaseStep))
                q_words.push_back(o_PhaseStep);
            if (o_done && g_done_at < 0) g_done_at = c;
            // start is only ever offered where it must be ignored (busy or DONE)
            i_start = (q_exp[c][2] | q_exp[c][1]) ? 1'($urandom_range(0, 1)) : 1'b0;
            i_stop  = (c == stop_at) ? 1'b1 : (q_exp[c][2] ? 1'b0 : 1'($urandom_range(0, 1)));
            rand_cfg();
        end
        i_start = 1'b0;
        i_stop  = 1'b0;
    endtask

    task automatic set_vec(input int i, input logic [31:0] s, input logic [31:0] e,
                           input logic [31:0] inc, input logic [23:0] dw, input logic [1:0] md,
                           input int stop_at, input int done_cyc, input int nw,
                           input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                           input logic [31:0] w3, input logic [31:0] w4, input logic [31:0] w5,
                           input logic [31:0] w6, input logic [31:0] w7);
        vt[i].s = s; vt[i].e = e; vt[i].inc = inc; vt[i].dw = dw; vt[i].md = md;
        vt[i].stop_at = stop_at; vt[i].done_cyc = done_cyc; vt[i].nw = nw;
        vt[i].w[0] = w0; vt[i].w[1] = w1; vt[i].w[2] = w2; vt[i].w[3] = w3;
        vt[i].w[4] = w4; vt[i].w[5] = w5; vt[i].w[6] = w6; vt[i].w[7] = w7;
    endtask

    task automatic expect_all_zero(input string nm);
        chk(nm, {28'd0, o_PhaseStep, o_phase_reset, o_busy, o_done, o_marker}, 64'd0);
    endtask

    initial begin
        logic [31:0] s, e, inc, diff;
        logic [23:0] dw;
        logic [1:0]  md;
        int          kind, stop_at;

        // words listed are the distinct consecutive values seen while busy
        set_vec(0, 100, 400, 100, 3, 0, -1, 13, 4, 100, 200, 300, 400, 0, 0, 0, 0);
        set_vec(1, 100, 350, 100, 2, 0, -1,  9, 4, 100, 200, 300, 350, 0, 0, 0, 0);
        set_vec(2, 32'hFFFFFF00, 32'hFFFFFFFF, 32'h80, 1, 0, -1, 4, 3,
                32'hFFFFFF00, 32'hFFFFFF80, 32'hFFFFFFFF, 0, 0, 0, 0, 0);
        set_vec(3, 400, 100, 150, 1, 2, 8, 9, 8, 400, 250, 100, 250, 400, 250, 100, 250);
        set_vec(4, 10, 20, 10, 0, 1, 6, 7, 6, 10, 20, 10, 20, 10, 20, 0, 0);
        set_vec(5, 50, 50, 7, 2, 0, -1, 3, 1, 50, 0, 0, 0, 0, 0, 0, 0);
        set_vec(6, 5, 9, 0, 1, 0, 10, 11, 1, 5, 0, 0, 0, 0, 0, 0, 0);
        set_vec(7, 100, 0, 300, 1, 0, -1, 3, 2, 100, 0, 0, 0, 0, 0, 0, 0);
        set_vec(8, 10, 30, 10, 1, 3, -1, 4, 3, 10, 20, 30, 0, 0, 0, 0, 0);

        rst_n = 1'b0;
        i_start = 1'b0;
        i_stop = 1'b0;
        i_StartPhaseStep = '0;
        i_StopPhaseStep = '0;
        i_StepIncrement = '0;
        i_DwellCycles = '0;
        i_Mode = '0;
        #1;
        expect_all_zero("reset immediate");
        repeat (3) @(negedge clk);
        expect_all_zero("reset held");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        expect_all_zero("idle after reset");

        for (int i = 0; i < 9; i++) begin
            run_sweep(vt[i].s, vt[i].e, vt[i].inc, vt[i].dw, vt[i].md, vt[i].stop_at, i);
            chk($sformatf("vec%0d word count", i), 64'(q_words.size()), 64'(vt[i].nw));
            for (int k = 0; k < vt[i].nw && k < q_words.size(); k++)
                chk($sformatf("vec%0d word%0d", i, k), 64'(q_words[k]), 64'(vt[i].w[k]));
            chk($sformatf("vec%0d done cycle", i), 64'(g_done_at), 64'(vt[i].done_cyc));
        end

        for (int t = 0; t < 40; t++) begin
            kind = int'($urandom_range(0, 3));
            md   = 2'($urandom_range(0, 3));
            dw   = 24'($urandom_range(0, 4));
            s    = $urandom;
            e    = $urandom;
            if (kind == 1) begin
                s = 32'hFFFFFFFF - $urandom_range(0, 1000);
                e = 32'hFFFFFFFF - $urandom_range(0, 1000);
            end else if (kind == 2) begin
                s = $urandom_range(0, 1000);
                e = $urandom_range(0, 1000);
            end
            diff = (e >= s) ? e - s : s - e;
            inc  = diff / $urandom_range(1, 6) + $urandom_range(1, 97);
            if (kind == 3) begin
                if ($urandom_range(0, 1) == 0) inc = 0;
                else e = s;
            end
            if ((md == 2'd0 || md == 2'd3) && inc != 0)
                stop_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 30)) : -1;
            else
                stop_at = int'($urandom_range(0, 50));
            run_sweep(s, e, inc, dw, md, stop_at, 100 + t);
        end

        // Asynchronous reset in the middle of a dwell
        @(negedge clk);
        i_StartPhaseStep = 100; i_StopPhaseStep = 400; i_StepIncrement = 100;
        i_DwellCycles = 3; i_Mode = 0; i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (5) @(negedge clk);
        chk("busy before mid-dwell reset", {63'd0, o_busy}, 64'd1);
        chk("phase before mid-dwell reset", 64'(o_PhaseStep), 64'd200);
        #2 rst_n = 1'b0;
        #1 expect_all_zero("mid-dwell reset immediate");
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            expect_all_zero($sformatf("idle after release c%0d", c));
        end

        // start and stop in the same IDLE cycle: stop wins, nothing starts
        i_start = 1'b1; i_stop = 1'b1;
        @(negedge clk);
        i_start = 1'b0; i_stop = 1'b0;
        expect_all_zero("start+stop same cycle");
        @(negedge clk);
        expect_all_zero("start+stop next cycle");
        i_stop = 1'b1;
        @(negedge clk);
        i_stop = 1'b0;
        expect_all_zero("stop in idle");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
